// File: rtl/can_opb_sched_if.sv
// rtl/can_opb_sched_if.sv - requester and CAN-side signal bundle for can_opb_sched
interface can_opb_sched_if;
  logic        M0_REQ, M1_REQ, M0_WE, M1_WE;
  logic [15:0] M0_ADDR, M1_ADDR;
  logic [31:0] M0_DI, M1_DI;
  logic        M0_ACK, M1_ACK, M0_ERR, M1_ERR;
  logic [31:0] M0_DO, M1_DO;
  logic [15:0] CAN_ADDR;
  logic [31:0] CAN_DI;
  logic        CAN1_RE, CAN2_RE, CAN3_RE, CAN4_RE;
  logic        CAN1_WE, CAN2_WE, CAN3_WE, CAN4_WE;
  logic [31:0] CAN1_DO, CAN2_DO, CAN3_DO, CAN4_DO;
  logic        BUSY;

  modport slave (
    input  M0_REQ, M1_REQ, M0_WE, M1_WE, M0_ADDR, M1_ADDR, M0_DI, M1_DI,
    input  CAN1_DO, CAN2_DO, CAN3_DO, CAN4_DO,
    output M0_ACK, M1_ACK, M0_ERR, M1_ERR, M0_DO, M1_DO,
    output CAN_ADDR, CAN_DI,
    output CAN1_RE, CAN2_RE, CAN3_RE, CAN4_RE,
    output CAN1_WE, CAN2_WE, CAN3_WE, CAN4_WE,
    output BUSY
  );

  modport master (
    output M0_REQ, M1_REQ, M0_WE, M1_WE, M0_ADDR, M1_ADDR, M0_DI, M1_DI,
    output CAN1_DO, CAN2_DO, CAN3_DO, CAN4_DO,
    input  M0_ACK, M1_ACK, M0_ERR, M1_ERR, M0_DO, M1_DO,
    input  CAN_ADDR, CAN_DI,
    input  CAN1_RE, CAN2_RE, CAN3_RE, CAN4_RE,
    input  CAN1_WE, CAN2_WE, CAN3_WE, CAN4_WE,
    input  BUSY
  );
endinterface

// File: rtl/can_opb_sched.sv
// rtl/can_opb_sched.sv - round-robin two-master scheduler for the four CAN register windows
module can_opb_sched #(
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned GAP_CYC  = 1
) (
  input  logic           OPB_CLK,
  input  logic           OPB_RST_N,
  can_opb_sched_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_STROBE, S_WAIT, S_DONE, S_ERR, S_GAP} state_t;

  localparam logic [3:0] READ_LAT_C = 4'(READ_LAT);
  localparam logic [3:0] GAP_C      = 4'(GAP_CYC);
  localparam bit         HAS_GAP    = (GAP_CYC != 0);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] di_q, di_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        req_any, gnt_sel, sel_we, sel_valid;
  logic [15:0] sel_addr;
  logic [31:0] sel_di, can_do_sel;

  // A tie goes to whoever was not served last; last_q resets to M1 so M0 wins first.
  assign req_any  = bus.M0_REQ | bus.M1_REQ;
  assign gnt_sel  = (bus.M0_REQ & bus.M1_REQ) ? ~last_q : bus.M1_REQ;
  assign sel_we   = gnt_sel ? bus.M1_WE   : bus.M0_WE;
  assign sel_addr = gnt_sel ? bus.M1_ADDR : bus.M0_ADDR;
  assign sel_di   = gnt_sel ? bus.M1_DI   : bus.M0_DI;

  always_comb begin
    sel_valid = 1'b0;
    case (sel_addr[14:11])
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sel_valid = 1'b1;
      default:                            sel_valid = 1'b0;
    endcase
  end

  always_comb begin
    can_do_sel = '0;
    case (addr_q[14:11])
      4'b0001: can_do_sel = bus.CAN1_DO;
      4'b0010: can_do_sel = bus.CAN2_DO;
      4'b0100: can_do_sel = bus.CAN3_DO;
      4'b1000: can_do_sel = bus.CAN4_DO;
      default: can_do_sel = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    di_d    = di_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          gnt_d   = gnt_sel;
          we_d    = sel_we;
          addr_d  = sel_addr;
          di_d    = sel_di;
          state_d = sel_valid ? S_STROBE : S_ERR;
        end
      end
      S_STROBE: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = READ_LAT_C;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rdata_d = can_do_sel;
          state_d = S_DONE;
        end
      end
      S_DONE, S_ERR: begin
        last_d = gnt_q;
        if (HAS_GAP) begin
          cnt_d   = GAP_C;
          state_d = S_GAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      di_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes and acks decode straight from the state register so reset kills them at once.
  logic stb, ack, done_rd;
  assign stb     = (state_q == S_STROBE);
  assign ack     = (state_q == S_DONE) || (state_q == S_ERR);
  assign done_rd = (state_q == S_DONE) && !we_q;

  assign bus.CAN1_RE = stb & ~we_q & addr_q[11];
  assign bus.CAN2_RE = stb & ~we_q & addr_q[12];
  assign bus.CAN3_RE = stb & ~we_q & addr_q[13];
  assign bus.CAN4_RE = stb & ~we_q & addr_q[14];
  assign bus.CAN1_WE = stb &  we_q & addr_q[11];
  assign bus.CAN2_WE = stb &  we_q & addr_q[12];
  assign bus.CAN3_WE = stb &  we_q & addr_q[13];
  assign bus.CAN4_WE = stb &  we_q & addr_q[14];

  assign bus.M0_ACK   = ack & ~gnt_q;
  assign bus.M1_ACK   = ack &  gnt_q;
  assign bus.M0_ERR   = (state_q == S_ERR) & ~gnt_q;
  assign bus.M1_ERR   = (state_q == S_ERR) &  gnt_q;
  assign bus.M0_DO    = (done_rd & ~gnt_q) ? rdata_q : '0;
  assign bus.M1_DO    = (done_rd &  gnt_q) ? rdata_q : '0;
  assign bus.CAN_ADDR = addr_q;
  assign bus.CAN_DI   = di_q;
  assign bus.BUSY     = (state_q != S_IDLE);
endmodule

// File: doc/can_opb_sched.md
# can_opb_sched

Two-master access scheduler for the four CAN controller register windows on the OPB side. It sits between two requesters and the CAN interface block: master 0 is the host OPB slave decode and master 1 is the background status poller. It arbitrates round-robin, decodes the channel from address bits [14:11] and issues exactly one single-cycle RE/WE strobe to the selected controller. For reads it waits a fixed latency, captures that controller's data bus and returns it with a one-cycle acknowledge.

## Interface
- READ_LAT, 2: cycles from the end of the RE strobe cycle to the CANx_DO capture edge; legal range 1..15.
- GAP_CYC, 1: idle cycles inserted after every ACK before the next grant; legal range 0..15.

- OPB_CLK  in  1  sole clock, rising edge.
- OPB_RST_N  in  1  asynchronous, active-low reset.
- M0_REQ, M1_REQ  in  1  access request; held high with stable ADDR/WE/DI until ACK.
- M0_WE, M1_WE  in  1  1 = write, 0 = read.
- M0_ADDR, M1_ADDR  in  16  register address; [14:11] is the one-hot channel select (0001 = CAN1, 0010 = CAN2, 0100 = CAN3, 1000 = CAN4).
- M0_DI, M1_DI  in  32  write data.
- M0_ACK, M1_ACK  out  1  one-cycle completion pulse.
- M0_ERR, M1_ERR  out  1  high together with ACK when the channel decode is invalid.
- M0_DO, M1_DO  out  32  read data, valid only while ACK is high; 0 for writes and errors.
- CAN_ADDR  out  16  registered address to the CAN interface.
- CAN_DI  out  32  registered write data to the CAN interface.
- CAN1_RE..CAN4_RE, CAN1_WE..CAN4_WE  out  1  per-channel strobes.
- CAN1_DO..CAN4_DO  in  32  per-channel read data.
- BUSY  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, STROBE, WAIT, DONE, ERR, GAP.
- **IDLE:** when any REQ is sampled high, grant a master and latch its ADDR, WE and DI.
  - Arbitration is round-robin: if both request, the master not granted last wins.
  - The pointer resets to favour M0.
  - If ADDR[14:11] is one-hot, go to STROBE. Otherwise (0000 or more than one bit set) go to ERR.
- **STROBE:** CAN_ADDR and CAN_DI hold the latched values from STROBE entry until the next grant.
  - Exactly one of the eight strobes is high, for this cycle only.
  - Write: go to DONE. Read: load the counter with READ_LAT and go to WAIT.
- **WAIT:** decrement the counter each cycle.
  - At the edge where the counter reaches 0, capture the selected CANx_DO into the read register and go to DONE.
- **DONE:** the granted master's ACK is high for one cycle, with DO = captured data (reads) or 0 (writes). Update the round-robin pointer.
  - Then go to GAP if GAP_CYC > 0, else to IDLE.
- **ERR:** ACK and ERR are high for one cycle and DO = 0. No strobe is issued. Next state follows the same rule as DONE.
- **GAP:** count GAP_CYC cycles, then go to IDLE.
- **Handshake:** a REQ that is high on the edge ending the ACK cycle belongs to the old transaction. It is not re-sampled until IDLE.
  - A master that still has REQ high in IDLE is treated as issuing a new request.
- **Non-granted master:** ACK, ERR and DO stay 0.

## Timing
- **Reset values (asynchronous assertion):**
  - State = IDLE, pointer = M0.
  - All RE/WE, ACK and ERR outputs = 0; BUSY = 0.
  - CAN_ADDR = 0, CAN_DI = 0, M0_DO = M1_DO = 0.
- **Reset mid-operation:** the strobe drops immediately, no ACK is ever issued for the aborted access, and masters must reissue.
- **Latency,** counting cycle 0 as the IDLE sampling edge:
  - Write: strobe in cycle 1, ACK in cycle 2.
  - Read: RE in cycle 1, capture at the end of cycle 1+READ_LAT, ACK in cycle 2+READ_LAT.
  - Error: ACK+ERR in cycle 1.
- **Throughput:** the minimum spacing between grants is (access cycles + GAP_CYC + 1).
- **Simultaneous requests:** when M0 and M1 request on the same IDLE edge, they alternate strictly.

## Test plan
- **Reset:** after reset release with no requests, all strobes, ACKs and BUSY stay 0 for 20 cycles.
- **Single write:** M0 writes ADDR 0x0800, DI 0x12345678.
  - CAN1_WE is high for exactly 1 cycle with CAN_ADDR = 0x0800 and CAN_DI = 0x12345678.
  - M0_ACK follows 1 cycle later with M0_DO = 0.
- **Single read:** M1 reads 0x4000 with CAN4_DO driven to 0xDEADBEEF.
  - CAN4_RE pulses once.
  - M1_ACK arrives 2+READ_LAT cycles after the request is sampled, with M1_DO = 0xDEADBEEF.
- **Contention:** M0 and M1 request continuously (reads to 0x1000 and 0x2000).
  - Grants alternate M0, M1, M0, M1.
  - Strobes never overlap and are separated by GAP_CYC idle cycles.
- **Invalid decode:** M0 reads 0x1800 (bits 0011) or 0x0000.
  - M0_ACK and M0_ERR are high together 1 cycle after sampling, with M0_DO = 0.
  - No RE/WE fires.
- **Reset mid-read:** assert OPB_RST_N low during WAIT.
  - Outputs clear asynchronously and no ACK appears.
  - After release, the reissued read to 0x2000 completes normally with the CAN3_DO value.
